rr_arbiter16_ctrl: RTL and testbench
====================================

// Module: rr_arbiter16_ctrl
// PURPOSE
//  Round-robin arbiter sharing one 32-bit 16:1 mux (16-master read bus) among 16 requesters.
//  Grants one owner at a time and drives the mux selects {s3,s2,s1,s0} directly.
//  Hold-time limit preempts an owner when other masters are waiting.
//  Sits between master request lines and the bus mux select inputs.
// PARAMETERS
//  MAX_HOLD  8  max consecutive grant cycles for one owner while others request (>=1)
// PORTS
//  clk       in   1   system clock, rising edge
//  reset_n   in   1   asynchronous active-low reset
//  req       in   16  request per master; bit i = master i
//  grant     out  16  one-hot grant to current owner; 0 when no owner
//  sel       out  4   owner index; sel[3:0] -> mux s3,s2,s1,s0
//  busy      out  1   1 while an owner holds the bus
// BEHAVIOUR
//  Reset (async, reset_n=0): grant=0, sel=0, busy=0, state=IDLE, ptr=0, hold_cnt=0.
//   Takes effect immediately, no clock needed; mid-grant reset drops owner at once.
//  All outputs registered; req sampled at rising edge; grant visible after that same edge.
//  Candidate search: first i with req[i]=1 scanning ptr, ptr+1, ..., 15, 0, ... (mod 16).
//  ptr = priority start; after a grant to index k, ptr <= (k+1) mod 16 (15 wraps to 0).
//  FSM states:
//   IDLE : req==0 -> stay, outputs unchanged (sel keeps last owner, grant=0, busy=0).
//          req!=0 -> grant candidate c: grant=1<<c, sel=c, busy=1, hold_cnt=0 -> GRANT.
//   GRANT: owner o = sel.
//    req[o]=0, other req pending -> hand off to next candidate same edge (no idle cycle).
//    req[o]=0, no other req      -> grant=0, busy=0, sel holds o -> IDLE.
//    req[o]=1, other req pending, hold_cnt==MAX_HOLD-1 -> preempt: grant next
//          candidate (search excludes o), hold_cnt=0.
//    req[o]=1, otherwise -> keep grant; hold_cnt increments only while others
//          pending, clears to 0 when no other requester.
//  Owner grant length with contention = exactly MAX_HOLD cycles.
//  Simultaneous: owner drop + new requests on same edge -> handoff, not IDLE.
//  Request from preempted owner re-enters round-robin normally (lowest priority after grant).
//  grant is always one-hot or zero; grant[sel]==busy at all times.
//  No X propagation: req with X not required to be handled.
// TESTING
//  1 reset_n=0 with req=16'hFFFF -> grant=0,sel=0,busy=0 without clock; release reset ->
//    next edge grant=16'h0001,sel=0,busy=1.
//  2 IDLE,ptr=0,req=16'h0090 -> grant=16'h0010,sel=4; drop req[4] -> next edge
//    grant=16'h0080,sel=7, busy stays 1 (no gap).
//  3 wrap: owner 15, req=16'h8009 then drop bit15 -> grant=16'h0001,sel=0; ptr=1.
//  4 MAX_HOLD=8: req[2] and req[5] held high, owner 2 -> grant bit2 exactly 8 cycles,
//    then grant=16'h0020,sel=5 for 8 cycles, then back to 2.
//  5 lone owner 3 holds req 20 cycles, no other req -> grant=16'h0008 all 20 cycles;
//    req[6] rises -> preempt after 8 more cycles.
//  6 reset_n pulsed low mid-GRANT between edges -> grant=0,busy=0,sel=0 immediately;
//    after release arbitration restarts from ptr=0.

Source files
------------

// File: rtl/rr_arbiter16_ctrl_if.sv
// Bus-side bundle of the 16-master round-robin arbiter: request lines in,
// one-hot grant plus mux select and busy flag out.
interface rr_arbiter16_ctrl_if;
    // Handshake: master i holds req[i] high for as long as it wants the bus.
    // It owns the bus only in cycles where grant[i] is high. grant changes
    // only on a rising clk edge, as a result of req sampled at that edge.
    // Dropping req[i] releases the bus at the next edge.
    logic [15:0] req;
    logic [15:0] grant;
    logic [3:0]  sel;
    logic        busy;

    modport master (output req, input grant, input sel, input busy);
    modport slave  (input req, output grant, output sel, output busy);
endinterface

// File: rtl/rr_arbiter16_ctrl.sv
// Round-robin owner arbiter for a shared 32-bit 16:1 read mux. It drives the mux
// selects directly and preempts an owner after MAX_HOLD contended cycles.
module rr_arbiter16_ctrl #(
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    rr_arbiter16_ctrl_if.slave   arb,
    output logic                 dbg_state_o
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t        state_q;
    logic [3:0]    ptr_q;
    logic [HW-1:0] hold_q;
    logic [15:0]   grant_q;
    logic [3:0]    sel_q;
    logic          busy_q;

    logic [15:0]   owner_bit;
    logic [15:0]   cand_mask;
    logic [4:0]    cand;
    logic          cand_vld;
    logic [3:0]    cand_idx;
    logic          owner_req;

    // Returns {found, index} of the first set bit at or after start, wrapping mod 16.
    function automatic logic [4:0] rr_pick(input logic [15:0] mask, input logic [3:0] start);
        logic [3:0] idx;
        rr_pick = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            idx = start + 4'(i);
            if (mask[idx]) rr_pick = {1'b1, idx};
        end
    endfunction

    always_comb begin
        owner_bit = 16'd0;
        if (state_q == GRANT) owner_bit = 16'd1 << sel_q;
        // The current owner never competes in its own handoff or preemption.
        cand_mask = arb.req & ~owner_bit;
        cand      = rr_pick(cand_mask, ptr_q);
        cand_vld  = cand[4];
        cand_idx  = cand[3:0];
        owner_req = arb.req[sel_q];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= 4'd0;
            hold_q  <= '0;
            grant_q <= 16'd0;
            sel_q   <= 4'd0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cand_vld) begin
                        grant_q <= 16'd1 << cand_idx;
                        sel_q   <= cand_idx;
                        busy_q  <= 1'b1;
                        hold_q  <= '0;
                        ptr_q   <= cand_idx + 4'd1;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if ((!owner_req || hold_q == HOLD_LAST) && cand_vld) begin
                        // Handoff on release, or preemption at the hold limit.
                        grant_q <= 16'd1 << cand_idx;
                        sel_q   <= cand_idx;
                        hold_q  <= '0;
                        ptr_q   <= cand_idx + 4'd1;
                    end else if (!owner_req) begin
                        grant_q <= 16'd0;
                        busy_q  <= 1'b0;
                        hold_q  <= '0;
                        state_q <= IDLE;
                    end else if (cand_vld) begin
                        hold_q  <= hold_q + 1'b1;
                    end else begin
                        hold_q  <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign arb.grant   = grant_q;
    assign arb.sel     = sel_q;
    assign arb.busy    = busy_q;
    assign dbg_state_o = (state_q == GRANT);

endmodule

// File: tb/tb_rr_arbiter16_ctrl.sv
// Randomised and directed bench for rr_arbiter16_ctrl, checked by a queue-based
// scoreboard fed from a behavioural round-robin ownership model.
module tb_rr_arbiter16_ctrl;

    localparam int MAX_HOLD = 8;

    logic clk;
    logic reset_n;
    logic dbg_state;

    rr_arbiter16_ctrl_if arb_if ();

    rr_arbiter16_ctrl #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .arb         (arb_if.slave),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // owner = -1 means nobody holds the bus; tenure counts contended cycles.
    int m_owner;
    int m_ptr;
    int m_sel;
    int m_tenure;

    int n_cmp;
    int n_err;
    int cyc;

    logic [20:0] exp_q[$];

    function automatic int pick(input logic [15:0] mask);
        for (int i = 0; i < 16; i++) begin
            if (mask[(m_ptr + i) % 16]) return (m_ptr + i) % 16;
        end
        return -1;
    endfunction

    task automatic model_give(input int k);
        m_owner  = k;
        m_sel    = k;
        m_ptr    = (k + 1) % 16;
        m_tenure = 0;
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_ptr    = 0;
        m_sel    = 0;
        m_tenure = 0;
    endtask

    task automatic model_step(input logic [15:0] r);
        logic [15:0] others;
        others = r;
        if (m_owner >= 0) others[m_owner] = 1'b0;
        if (m_owner < 0) begin
            if (r != 16'd0) model_give(pick(r));
        end else if (!r[m_owner]) begin
            if (others != 16'd0) model_give(pick(others));
            else m_owner = -1;
        end else if (others != 16'd0) begin
            if (m_tenure + 1 == MAX_HOLD) model_give(pick(others));
            else m_tenure++;
        end else begin
            m_tenure = 0;
        end
    endtask

    function automatic logic [20:0] model_out();
        logic [15:0] g;
        g = 16'd0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return {g, 4'(m_sel), (m_owner >= 0)};
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic [15:0] r);
        arb_if.req = r;
        model_step(r);
        exp_q.push_back(model_out());
    endtask

    task automatic cycle(input logic [15:0] r);
        @(negedge clk);
        drive(r);
    endtask

    task automatic check_out(input string name, input logic [20:0] exp);
        logic [20:0] got;
        got = {arb_if.grant, arb_if.sel, arb_if.busy};
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got grant=%h sel=%0d busy=%b, expected grant=%h sel=%0d busy=%b",
                     name, got[20:5], got[4:1], got[0], exp[20:5], exp[4:1], exp[0]);
        end
    endtask

    // Async reset mid-cycle; outputs must clear before any clock edge.
    task automatic pulse_reset(input string name);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1 check_out(name, 21'd0);
        model_reset();
        @(negedge clk);
        arb_if.req = 16'd0;
        reset_n    = 1'b1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) begin
        #2;
        cyc++;
        if (exp_q.size() != 0) check_out($sformatf("scoreboard cyc %0d", cyc), exp_q.pop_front());
    end

    // ---------------- stimulus ----------------
    logic [15:0] cur;

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        model_reset();
        reset_n    = 1'b1;
        arb_if.req = 16'hFFFF;

        // 1: reset with all requests, no clock edge yet
        #3 reset_n = 1'b0;
        #1 check_out("reset_no_clock", 21'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        drive(16'hFFFF);
        cycle(16'h0000);
        cycle(16'h0000);

        // 2: handoff without an idle gap
        pulse_reset("reset_t2");
        cycle(16'h0090);
        cycle(16'h0080);
        cycle(16'h0000);

        // 3: wrap from owner 15 to 0
        pulse_reset("reset_t3");
        cycle(16'h8000);
        cycle(16'h8009);
        cycle(16'h0009);
        cycle(16'h0006);
        cycle(16'h0000);

        // 4: two contenders alternate every MAX_HOLD cycles
        pulse_reset("reset_t4");
        cycle(16'h0004);
        repeat (20) cycle(16'h0024);
        cycle(16'h0000);

        // 5: lone owner is never preempted until someone else asks
        pulse_reset("reset_t5");
        repeat (20) cycle(16'h0008);
        repeat (12) cycle(16'h0048);
        cycle(16'h0000);

        // 6: reset mid-grant, then restart from ptr 0
        cycle(16'h0400);
        cycle(16'h0400);
        pulse_reset("reset_mid_grant");
        cycle(16'hFFFF);
        cycle(16'hFFFF);
        cycle(16'h0000);

        // random phase: slowly mutating request vector with occasional resets
        cur = 16'd0;
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: cur = cur ^ (16'd1 << $urandom_range(0, 15));
                3:       cur = 16'($urandom);
                4:       if ($urandom_range(0, 7) == 0) cur = 16'd0;
                default: ;
            endcase
            cycle(cur);
            if (n % 400 == 399) pulse_reset($sformatf("reset_rand_%0d", n));
        end

        cycle(16'h0000);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
